// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB responder backed by a word-addressed register memory.
// Decoded by one bit of the bridge's one-hot PSEL, with a fixed wait-state count and PSLVERR
// for accesses outside the window or not word-aligned.
// Build option APB_SLV_WAIT_EN: when defined, WAIT_CYCLES wait states are inserted through a
// 4-bit counter and a WAIT state. When undefined, every transfer completes one cycle after setup.
module apb_slave_mem #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned SEL_IDX     = 0,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [2:0]  PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  localparam int unsigned IdxW   = $clog2(DEPTH);
  localparam logic [1:0]  SelBit = 2'(SEL_IDX);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd2;
`ifdef APB_SLV_WAIT_EN
  localparam logic [1:0] StWait   = 2'd1;
  localparam logic [3:0] WaitCnt  = 4'(WAIT_CYCLES);
`endif

  logic [1:0]      state_q, state_d;
  logic            pready_q, pready_d;
  logic            pslverr_q, pslverr_d;
  logic [IdxW-1:0] idx_q;
  logic            write_q, err_q;
  logic [31:0]     wdata_q;
  logic [31:0]     mem_q [DEPTH];

  logic            sel, setup, addr_err, mem_we;
  logic [31:0]     addr_off;
  logic [32:0]     addr_top;
  logic            unused_bits;

  assign sel   = PSEL[SelBit];
  assign setup = sel & ~PENABLE;

  // Window end is one bit wider so a window reaching the top of the address space cannot wrap.
  assign addr_top = {1'b0, ADDR_BASE} + 33'(4 * DEPTH);
  assign addr_err = (PADDR < ADDR_BASE) || ({1'b0, PADDR} >= addr_top) || (PADDR[1:0] != 2'b00);
  assign addr_off = PADDR - ADDR_BASE;

`ifdef APB_SLV_WAIT_EN
  logic [3:0] cnt_q, cnt_d;
  assign unused_bits = ^{PSEL, addr_off};
`else
  // WAIT_CYCLES has no effect in this build.
  logic [3:0] unused_wait;
  assign unused_wait = 4'(WAIT_CYCLES);
  assign unused_bits = ^{PSEL, addr_off, unused_wait};
`endif

  // Next-state logic; PREADY/PSLVERR are decided one cycle ahead so they leave a flop.
  always_comb begin
    state_d   = state_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
`ifdef APB_SLV_WAIT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        // An enable phase without a preceding setup is ignored.
        if (setup) begin
`ifdef APB_SLV_WAIT_EN
          if (WaitCnt == 4'd0) begin
            state_d   = StAccess;
            pready_d  = 1'b1;
            pslverr_d = addr_err;
          end else begin
            state_d = StWait;
            cnt_d   = WaitCnt;
          end
`else
          state_d   = StAccess;
          pready_d  = 1'b1;
          pslverr_d = addr_err;
`endif
        end
      end
`ifdef APB_SLV_WAIT_EN
      StWait: begin
        // Losing PSEL mid-wait is a master abort and takes priority over completion.
        if (!sel) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d   = StAccess;
            pready_d  = 1'b1;
            pslverr_d = err_q;
          end
        end
      end
`endif
      StAccess: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM, response flops and the transfer captured during setup.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q   <= StIdle;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
`ifdef APB_SLV_WAIT_EN
      cnt_q     <= 4'd0;
`endif
    end else begin
      state_q   <= state_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
`ifdef APB_SLV_WAIT_EN
      cnt_q     <= cnt_d;
`endif
      if (state_q == StIdle && setup) begin
        idx_q   <= addr_off[IdxW+1:2];
        write_q <= PWRITE;
        err_q   <= addr_err;
        wdata_q <= PWDATA;
      end
    end
  end

  assign mem_we = (state_q == StAccess) && write_q && !err_q;

  // Memory array: cleared by reset, written on the edge that closes a good write access.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign PRDATA  = ((state_q == StAccess) && !write_q && !err_q) ? mem_q[idx_q] : 32'h0;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Testbench for apb_slave_mem: directed and random APB transfers, with expected responses
// queued at issue time and checked by an independent monitor whenever PREADY is seen.
module tb_apb_slave_mem;

  localparam logic [31:0] Base       = 32'h8000_0000;
  localparam int unsigned Depth      = 16;
  localparam int unsigned WaitCycles = 2;
`ifdef APB_SLV_WAIT_EN
  localparam int N = WaitCycles;
`else
  localparam int N = 0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [2:0]  PSEL = 3'b000;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PADDR = 32'h0;
  logic [31:0] PWDATA = 32'h0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  apb_slave_mem #(
    .ADDR_BASE  (Base),
    .DEPTH      (Depth),
    .SEL_IDX    (0),
    .WAIT_CYCLES(WaitCycles)
  ) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PWRITE (PWRITE),
    .PADDR  (PADDR),
    .PWDATA (PWDATA),
    .PRDATA (PRDATA),
    .PREADY (PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          rd;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic [31:0] mem_m [Depth];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Reference rules: the window is [Base, Base + 4*Depth), word-aligned only.
  function automatic bit err_of(logic [31:0] a);
    longint unsigned la, lb;
    la = a;
    lb = Base;
    return (la < lb) || (la >= lb + 4 * Depth) || (a[1:0] != 2'b00);
  endfunction

  function automatic int idx_of(logic [31:0] a);
    return int'(((a - Base) / 4) % Depth);
  endfunction

  function automatic void clear_model();
    foreach (mem_m[i]) mem_m[i] = 32'h0;
  endfunction

  // Monitor: every cycle either consumes one expected completion or checks the idle outputs.
  always @(negedge HCLK) begin
    if (mon_en) begin
      if (PREADY === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_pready", 32'(PREADY), 32'h0);
        end else begin
          cur = sb.pop_front();
          chk("ready_cycle", 32'(cyc), 32'(cur.cyc));
          chk("pslverr", 32'(PSLVERR), 32'(cur.err));
          if (cur.rd) chk("prdata", PRDATA, cur.data);
        end
      end else begin
        chk("pready_low", 32'(PREADY), 32'h0);
        chk("idle_prdata", PRDATA, 32'h0);
        chk("idle_pslverr", 32'(PSLVERR), 32'h0);
        if (sb.size() != 0 && sb[0].cyc < cyc) begin
          chk("missed_pready_cycle", 32'(cyc), 32'(sb[0].cyc));
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  // One APB transfer starting in the current cycle. abort_at / rst_at (>=0) drop PSEL or pulse
  // reset in enable-phase cycle k (cycle T+1+k).
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [2:0] sv, input int abort_at, input int rst_at);
    int t;
    int ix;
    bit e;
    bit commit;
    t  = cyc;
    e  = err_of(addr);
    ix = idx_of(addr);
    commit = 1'b0;
    PSEL = sv; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
    if (sv[0]) begin
      if (!(abort_at >= 0 && abort_at < N) && !(rst_at >= 0 && rst_at < N)) begin
        sb.push_back('{t + 1 + N, !wr, (e ? 32'h0 : mem_m[ix]), e});
      end
      commit = wr && !e && abort_at < 0 && rst_at < 0;
    end
    @(posedge HCLK);
    #1;
    // Bus values after setup must be ignored.
    PENABLE = 1'b1; PADDR = $urandom; PWDATA = $urandom;
    for (int k = 0; k <= N; k++) begin
      if (k == abort_at) begin
        PSEL = 3'b000; PENABLE = 1'b0;
        idle(1);
        break;
      end
      if (k == rst_at) begin
        HRESETn = 1'b0;
        idle(1);
        HRESETn = 1'b1;
        clear_model();
        break;
      end
      idle(1);
    end
    if (commit) mem_m[ix] = data;
    PSEL = 3'b000; PENABLE = 1'b0;
  endtask

  // Enable phase with no setup phase: must be ignored.
  task automatic stray();
    PSEL = 3'b001; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = Base; PWDATA = 32'hFFFF_FFFF;
    idle(3);
    PSEL = 3'b000; PENABLE = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  sv;
    int          kind, ab;
    clear_model();
    @(posedge HCLK);
    #1;
    mon_en = 1'b1;           // outputs must already be in reset state
    idle(1);
    HRESETn = 1'b1;

    // Write then read back.
    xfer(1'b1, Base + 32'h8, 32'hDEAD_BEEF, 3'b001, -1, -1);
    xfer(1'b0, Base + 32'h8, 32'h0, 3'b001, -1, -1);
    idle(2);

    // Out-of-range and misaligned accesses.
    xfer(1'b1, Base + 32'h40, 32'h1234_5678, 3'b001, -1, -1);
    xfer(1'b1, Base + 32'h6, 32'h1234_5678, 3'b001, -1, -1);
    xfer(1'b0, Base, 32'h0, 3'b001, -1, -1);
    xfer(1'b0, Base + 32'h40, 32'h0, 3'b001, -1, -1);
    xfer(1'b0, Base - 32'h4, 32'h0, 3'b001, -1, -1);
    xfer(1'b1, Base + 32'h3C, 32'h0BAD_CAFE, 3'b001, -1, -1);
    xfer(1'b0, Base + 32'h3C, 32'h0, 3'b001, -1, -1);

    // Another slave selected.
    for (int i = 0; i < 5; i++) xfer(1'b1, Base + 32'(4 * i), $urandom, 3'b010, -1, -1);
    xfer(1'b0, Base + 32'h4, 32'h0, 3'b001, -1, -1);
    stray();
    xfer(1'b0, Base, 32'h0, 3'b001, -1, -1);

`ifdef APB_SLV_WAIT_EN
    // Master abort during the wait phase.
    xfer(1'b1, Base + 32'hC, 32'hA5A5_A5A5, 3'b001, (N >= 2) ? 1 : 0, -1);
    idle(1);
    xfer(1'b0, Base + 32'hC, 32'h0, 3'b001, -1, -1);
`endif

    // Back-to-back writes then reads.
    for (int i = 0; i < 4; i++) xfer(1'b1, Base + 32'(4 * i), 32'(i + 1), 3'b001, -1, -1);
    for (int i = 0; i < 4; i++) xfer(1'b0, Base + 32'(4 * i), 32'h0, 3'b001, -1, -1);

    // Reset in the first enable-phase cycle of a write.
    xfer(1'b1, Base + 32'h10, 32'hCAFE_F00D, 3'b001, -1, 0);
    xfer(1'b0, Base + 32'h10, 32'h0, 3'b001, -1, -1);
    xfer(1'b0, Base + 32'h8, 32'h0, 3'b001, -1, -1);

    // Random traffic.
    for (int n = 0; n < 120; n++) begin
      kind = int'($urandom_range(9, 0));
      if (kind <= 6)      a = Base + 32'(4 * $urandom_range(Depth - 1, 0));
      else if (kind == 7) a = Base + 32'(4 * $urandom_range(Depth - 1, 0)) + 32'($urandom_range(3, 1));
      else if (kind == 8) a = Base + 32'(4 * Depth) + 32'(4 * $urandom_range(3, 0));
      else                a = Base - 32'(4 * $urandom_range(4, 1));
      case ($urandom_range(7, 0))
        0:       sv = 3'b010;
        1:       sv = 3'b100;
        default: sv = 3'b001;
      endcase
      ab = -1;
`ifdef APB_SLV_WAIT_EN
      if ($urandom_range(7, 0) == 0) ab = int'($urandom_range(N - 1, 0));
`endif
      xfer(1'($urandom), a, $urandom, sv, ab, -1);
      if ($urandom_range(3, 0) == 0) idle(int'($urandom_range(2, 1)));
    end

    idle(N + 4);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB responder holding a word-addressed register memory, sitting on the APB side of the AHB-to-APB bridge as one of the three peripherals decoded by the bridge's one-hot `PSEL[2:0]`. It accepts setup/enable transfers from the bridge FSM and inserts a fixed number of wait states via `PREADY`. It returns read data and commits write data. It flags illegal accesses with `PSLVERR`.

## Interface
- `ADDR_BASE`, default 32'h8000_0000: byte base address of the memory window.
- `DEPTH`, default 16: number of 32-bit words; power of two, 2..256.
- `SEL_IDX`, default 0: which bit of `PSEL[2:0]` selects this slave (0..2).
- `WAIT_CYCLES`, default 2: wait states per transfer (0..15).
- `HCLK` input 1: single clock; all logic on rising edge.
- `HRESETn` input 1: reset, synchronous and active-low.
- `PSEL` input 3: one-hot peripheral select from the bridge; only bit `SEL_IDX` is used.
- `PENABLE` input 1: APB enable (access) phase.
- `PWRITE` input 1: 1 = write, 0 = read.
- `PADDR` input 32: byte address.
- `PWDATA` input 32: write data.
- `PRDATA` output 32: read data; valid only while `PREADY`=1 on a read.
- `PREADY` output 1: transfer completes in this cycle.
- `PSLVERR` output 1: error response; valid only while `PREADY`=1.

## Operation
- `sel` = `PSEL[SEL_IDX]`.
- FSM states: IDLE, WAIT, ACCESS. Encoding is free.
- **IDLE**
  - `sel` & ~`PENABLE` (setup phase): latch `PADDR`, `PWRITE`, `PWDATA`; compute `err`.
  - If the effective wait count = 0: go to ACCESS and register `PREADY`=1.
  - Otherwise: load the counter with the wait count and go to WAIT.
  - `sel` & `PENABLE` seen in IDLE (no setup phase): ignored; stay IDLE; no `PREADY`.
- **WAIT**
  - Decrement the counter each cycle; `PREADY`=0.
  - When the counter reaches 1, go to ACCESS and register `PREADY`=1.
  - ~`sel` in WAIT (master abort): go to IDLE; no write; `PREADY`, `PSLVERR` stay 0.
- **ACCESS**
  - `PREADY`=1 for exactly one cycle.
  - Write with ~`err`: `mem[idx]` <= latched `PWDATA` on the closing edge.
  - Read with ~`err`: `PRDATA` = `mem[idx]`.
  - Any `err`: `PSLVERR`=1, `PRDATA`=0, memory unchanged.
  - Next state is IDLE. A back-to-back setup in the following cycle is accepted normally.
- `idx` = `(PADDR - ADDR_BASE) >> 2`, truncated to log2(`DEPTH`) bits.
- `err` = `PADDR` < `ADDR_BASE`, or `PADDR` >= `ADDR_BASE` + 4*`DEPTH`, or `PADDR[1:0]` != 0.
- `PRDATA` = 0 whenever `PREADY`=0.

## Timing
- Reset (`HRESETn`=0 at an edge): state IDLE, counter 0, `PREADY`=0, `PSLVERR`=0, `PRDATA`=0, all memory words 0. `PREADY`, `PSLVERR` and `PRDATA` take these values from that edge onward.
- Reset during WAIT or ACCESS aborts the transfer; no write occurs.
- Setup in cycle T; the master holds `PENABLE`=1 from T+1.
- `PREADY`=1 in cycle T+1+N, where N is the effective wait count.
- Write data is visible to a read whose setup is at T+2+N or later.
- Latency per transfer: N+2 cycles (setup + enable + N waits).
- `PREADY` and `PSLVERR` are registered outputs. `PRDATA` is combinational from `mem` and the latched `idx`, gated by ACCESS.
- The latched address, data and direction are used, so changes to `PADDR`/`PWDATA` after setup have no effect.

## Configuration
- `APB_SLV_WAIT_EN` defined: `WAIT_CYCLES` is honoured; the 4-bit counter and the WAIT state are built.
- `APB_SLV_WAIT_EN` undefined: effective wait count is 0; `WAIT_CYCLES` is ignored; no counter; every transfer completes with `PREADY`=1 in T+1.

## Test plan
- Write, then read back:
  - Stimulus: defaults, `WAIT_EN` defined, `PSEL`=3'b001. Write 32'hDEAD_BEEF to 32'h8000_0008, then read 32'h8000_0008.
  - Response: each transfer has `PREADY` low 2 cycles, then high 1; read `PRDATA`=32'hDEAD_BEEF; `PSLVERR`=0.
- Out-of-range and misaligned addresses:
  - Stimulus: write 32'h1234_5678 to 32'h8000_0040; write to 32'h8000_0006.
  - Response: `PSLVERR`=1 with `PREADY`; memory unchanged, so a read of 32'h8000_0000 returns 0.
- Other slave selected:
  - Stimulus: `PSEL`=3'b010 with `SEL_IDX`=0, 5 transfers.
  - Response: `PREADY` never asserts; memory unchanged.
- Master abort:
  - Stimulus: `WAIT_CYCLES`=4; drop `PSEL` during the 2nd wait cycle of a write of 32'hA5A5_A5A5.
  - Response: FSM returns to IDLE; a later read returns the old value, 0.
- Macro undefined, back-to-back reads:
  - Stimulus: `WAIT_EN` undefined; back-to-back reads of words 0..3 after writes of 1..4.
  - Response: `PREADY` high every second cycle; data 1, 2, 3, 4.
- Reset mid-transfer:
  - Stimulus: `HRESETn` low in the WAIT cycle of a write.
  - Response: the next edge gives `PREADY`=0, state IDLE, and the word reads 0 after reset release.
